tpu_cmd_sequencer: RTL
======================

TPU_CMD_SEQUENCER -- requirements
Module: tpu_cmd_sequencer

Interface
REQ-001 SHALL have parameter DIM, default 8: systolic array dimension and row count of A, B and C.
REQ-002 SHALL have parameter DATAW, default 64: width of the TPU bus and stream words.
REQ-003 SHALL have parameter ADDRW, default 16: width of the TPU address.
REQ-004 SHALL have parameter COMPUTE_CYCLES, default 3*DIM: wait cycles after the start command.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: begin one matmul job; sampled only in IDLE.
REQ-008 SHALL have port clr_c, input, 1 bit: zero C before compute; latched with start.
REQ-009 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATAW): operand stream.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, DATAW): result stream.
REQ-011 SHALL have ports tpu_r_w (output, 1) and tpu_addr (output, ADDRW): TPU bus control; r_w=1 is a write.
REQ-012 SHALL have ports tpu_wdata (output, DATAW) and tpu_rdata (input, DATAW): TPU write data and read data.
REQ-013 SHALL have ports busy (output, 1) and done (output, 1): busy means state is not IDLE; done is a one-cycle pulse.

Function
REQ-014 SHALL use the TPU address map: A row r = 0x100+8r; B row r = 0x200+8r; C row r, half h = 0x300+16r+8h; start = 0x400; idle = 0x000.
REQ-015 SHALL implement the states IDLE, LOAD_A, LOAD_B, CLR_C, KICK, WAIT, READ_C, DRAIN and DONE.
REQ-016 SHALL move from IDLE to LOAD_A on start=1, latching clr_c into clr_q; when not in IDLE, start SHALL be ignored.
REQ-017 SHALL hold in_ready=1 only in LOAD_A and LOAD_B.
REQ-018 SHALL, on each accepted word (in_valid & in_ready), combinationally drive tpu_r_w=1, the row address and tpu_wdata=in_data in that cycle, and increment the row counter.
REQ-019 SHALL drive tpu_r_w=1, tpu_addr=0x000 and tpu_wdata=0 in LOAD_A or LOAD_B cycles with no accepted word, and SHALL NOT advance the counter in those cycles.
REQ-020 SHALL take the order LOAD_A -> LOAD_B after DIM A words, then LOAD_B -> CLR_C after DIM B words if clr_q=1, else LOAD_B -> KICK.
REQ-021 SHALL, in CLR_C, issue 2*DIM consecutive writes in order of row then half, with tpu_wdata=0, one per cycle, then go to KICK.
REQ-022 SHALL, in KICK, drive tpu_addr=0x400 and tpu_r_w=0 for exactly one cycle, then go to WAIT.
REQ-023 SHALL hold WAIT for COMPUTE_CYCLES cycles with tpu_addr=0x000, then go to READ_C.
REQ-024 SHALL issue in READ_C 2*DIM reads in order of row then half (tpu_r_w=0).
REQ-025 SHALL issue a read only when the output register is empty or out_ready=1; on issue, tpu_rdata is captured at the clock edge into out_data, out_valid is set and the index advances.
REQ-026 SHALL, in READ_C cycles with no issued read, drive tpu_addr=0x000.
REQ-027 SHALL go to DRAIN after the last capture; DRAIN SHALL go to DONE when out_valid & out_ready.
REQ-028 SHALL hold out_valid until out_ready; the skid-free single register gives back-to-back throughput of 1 word/cycle with out_ready=1.
REQ-029 SHALL pulse done=1 for one cycle in DONE, then return to IDLE.
REQ-030 SHALL use a counter of $clog2(2*DIM+1) bits for load/clear/read indices and $clog2(COMPUTE_CYCLES+1) bits for WAIT; the counters clear on each state entry.
REQ-031 SHALL keep tpu_r_w=0, tpu_addr=0x000 and tpu_wdata=0 in all states not listed above.

Reset
REQ-032 SHALL, on rst_n=0 at any time including mid-job, immediately force: state=IDLE, counters=0, clr_q=0, out_valid=0, out_data=0, done=0, busy=0, in_ready=0, tpu_r_w=0, tpu_addr=0x000, tpu_wdata=0.
REQ-033 SHALL start the first job no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-034 SHALL cover a basic job: start, clr_c=1, A=identity, B rows 0x0807060504030201 (all rows), out_ready=1 -> bus shows 8 A writes, 8 B writes, 16 zero writes, one 0x400, 24 idle cycles, 16 reads; out words match the TPU model; a single done pulse.
REQ-035 SHALL cover in_valid toggling every other cycle -> no write on idle cycles and addresses stay contiguous 0x100..0x138, 0x200..0x238.
REQ-036 SHALL cover out_ready held low for 5 cycles mid-READ_C -> out_data stable, no new read issued, and no words lost or duplicated (exactly 16 beats).
REQ-037 SHALL cover start pulsed during WAIT -> ignored, and the job completes with exactly one done.
REQ-038 SHALL cover rst_n asserted in LOAD_B after 3 words -> all outputs at reset values in the same cycle; a fresh job afterwards completes normally.
REQ-039 SHALL cover clr_c=0 -> no 0x3xx writes before KICK.

Source files
------------

// File: rtl/tpu_cmd_sequencer.sv
// TPU command sequencer: streams A/B operand rows onto the TPU bus, optionally clears C,
// kicks one compute, waits it out, then streams C back through a single output register.
module tpu_cmd_sequencer #(
    parameter int unsigned DIM            = 8,
    parameter int unsigned DATAW          = 64,
    parameter int unsigned ADDRW          = 16,
    parameter int unsigned COMPUTE_CYCLES = 3 * DIM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr_c,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_wdata,
    input  logic [DATAW-1:0] tpu_rdata,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IdxW  = $clog2(2 * DIM + 1);
    localparam int unsigned WaitW = $clog2(COMPUTE_CYCLES + 1);

    localparam logic [IdxW-1:0]  LastRow  = IdxW'(DIM - 1);
    localparam logic [IdxW-1:0]  LastHalf = IdxW'(2 * DIM - 1);
    localparam logic [WaitW-1:0] LastWait = WaitW'(COMPUTE_CYCLES - 1);

    localparam logic [ADDRW-1:0] AddrA     = ADDRW'(16'h100);
    localparam logic [ADDRW-1:0] AddrB     = ADDRW'(16'h200);
    localparam logic [ADDRW-1:0] AddrC     = ADDRW'(16'h300);
    localparam logic [ADDRW-1:0] AddrStart = ADDRW'(16'h400);

    typedef enum logic [3:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StClrC,
        StKick,
        StWait,
        StReadC,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic              clr_q, clr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATAW-1:0]  out_data_q, out_data_d;

    logic              load_st;
    logic              accept;
    logic              issue;
    logic [ADDRW-1:0]  row_offs;

    assign load_st  = (state_q == StLoadA) || (state_q == StLoadB);
    assign accept   = load_st && in_valid;
    // A read is issued only if the output register is free by the next edge.
    assign issue    = (state_q == StReadC) && (!out_valid_q || out_ready);
    // Rows are 8 bytes apart; C halves interleave, so C (row, half) is also idx * 8.
    assign row_offs = ADDRW'({idx_q, 3'b000});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            wait_q      <= '0;
            clr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            clr_q       <= clr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoadA;
                    clr_d   = clr_c;
                end
            end
            StLoadA: if (accept && idx_q == LastRow) state_d = StLoadB;
            StLoadB: if (accept && idx_q == LastRow) state_d = clr_q ? StClrC : StKick;
            StClrC:  if (idx_q == LastHalf) state_d = StKick;
            StKick:  state_d = StWait;
            StWait:  if (wait_q == LastWait) state_d = StReadC;
            StReadC: if (issue && idx_q == LastHalf) state_d = StDrain;
            StDrain: if (out_valid_q && out_ready) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        idx_d  = idx_q;
        wait_d = wait_q;
        if (state_d != state_q) begin
            idx_d  = '0;
            wait_d = '0;
        end else begin
            case (state_q)
                StLoadA, StLoadB: if (accept) idx_d = idx_q + IdxW'(1);
                StClrC:           idx_d = idx_q + IdxW'(1);
                StReadC:          if (issue) idx_d = idx_q + IdxW'(1);
                StWait:           wait_d = wait_q + WaitW'(1);
                default:          ;
            endcase
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (issue) begin
            out_valid_d = 1'b1;
            out_data_d  = tpu_rdata;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        in_ready  = load_st;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        tpu_r_w   = 1'b0;
        tpu_addr  = '0;
        tpu_wdata = '0;
        case (state_q)
            StLoadA, StLoadB: begin
                tpu_r_w = 1'b1;
                if (accept) begin
                    tpu_addr  = ((state_q == StLoadA) ? AddrA : AddrB) + row_offs;
                    tpu_wdata = in_data;
                end
            end
            StClrC: begin
                tpu_r_w  = 1'b1;
                tpu_addr = AddrC + row_offs;
            end
            StKick:  tpu_addr = AddrStart;
            StReadC: if (issue) tpu_addr = AddrC + row_offs;
            default: ;
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
